// File: rtl/sd_spi_master_if.sv
// Host- and card-side signal bundle for the SD-card SPI master.
// The master modport is the controller's view; slave is the host/card side.
interface sd_spi_master_if;
    localparam int unsigned FRAME_W = 48;

    logic               spi_start_i;
    logic [FRAME_W-1:0] instruction_sd_i;
    logic               spi_fbo_i;
    logic [1:0]         clock_divider_i;
    logic               spi_MISO_i;
    logic               spi_SCK_o;
    logic               spi_MOSI_o;
    logic               spi_CS_o;
    logic [FRAME_W-1:0] spi_data_o;
    logic               spi_done_o;
    logic               spi_busy_o;

    modport master (
        input  spi_start_i, instruction_sd_i, spi_fbo_i, clock_divider_i, spi_MISO_i,
        output spi_SCK_o, spi_MOSI_o, spi_CS_o, spi_data_o, spi_done_o, spi_busy_o
    );

    modport slave (
        output spi_start_i, instruction_sd_i, spi_fbo_i, clock_divider_i, spi_MISO_i,
        input  spi_SCK_o, spi_MOSI_o, spi_CS_o, spi_data_o, spi_done_o, spi_busy_o
    );
endinterface

// File: rtl/sd_spi_master.sv
// Mode-0 SPI master exchanging one 48-bit SD command frame per request,
// with selectable bit order, four SCK rates and a four-phase start/done handshake.
module sd_spi_master (
    input  logic            spi_clk_i,
    input  logic            spi_rst_i,
    sd_spi_master_if.master bus
);
    localparam int unsigned FRAME_W = 48;
    localparam int unsigned BIT_W   = 6;
    localparam int unsigned DIV_W   = 7;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]   half_q, half_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic               fbo_q, fbo_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               cs_q, cs_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    // Terminal count of the half-period counter (H - 1).
    function automatic logic [DIV_W-1:0] half_last(input logic [1:0] sel);
        case (sel)
            2'd0:    half_last = DIV_W'(1);
            2'd1:    half_last = DIV_W'(3);
            2'd2:    half_last = DIV_W'(7);
            default: half_last = DIV_W'(127);
        endcase
    endfunction

    function automatic logic [FRAME_W-1:0] bit_reverse(input logic [FRAME_W-1:0] v);
        logic [FRAME_W-1:0] r;
        for (int i = 0; i < FRAME_W; i++) r[i] = v[FRAME_W-1-i];
        return r;
    endfunction

    // Frames are held MSB-first internally; LSB-first traffic is mirrored at the edges.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        half_d    = half_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_d    = data_q;
        fbo_d     = fbo_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;

        case (state_q)
            IDLE: begin
                if (bus.spi_start_i) begin
                    state_d   = CS_SETUP;
                    fbo_d     = bus.spi_fbo_i;
                    half_d    = half_last(bus.clock_divider_i);
                    tx_d      = bus.spi_fbo_i ? bus.instruction_sd_i
                                              : bit_reverse(bus.instruction_sd_i);
                    mosi_d    = bus.spi_fbo_i ? bus.instruction_sd_i[FRAME_W-1]
                                              : bus.instruction_sd_i[0];
                    rx_d      = '0;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    sck_d     = 1'b0;
                end
            end
            CS_SETUP: begin
                if (div_cnt_q == half_q) begin
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_cnt_q == half_q) begin
                    div_cnt_d = '0;
                    sck_d     = ~sck_q;
                    if (!sck_q) begin
                        rx_d = {rx_q[FRAME_W-2:0], bus.spi_MISO_i};
                    end else if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        mosi_d    = 1'b1;
                        state_d   = CS_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = {tx_q[FRAME_W-2:0], 1'b1};
                        mosi_d    = tx_q[FRAME_W-2];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            CS_HOLD: begin
                if (div_cnt_q == half_q) begin
                    div_cnt_d = '0;
                    data_d    = fbo_q ? rx_q : bit_reverse(rx_q);
                    mosi_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            DONE: begin
                if (!bus.spi_start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD);
        cs_d   = ~busy_d;
        done_d = (state_d == DONE);
    end

    always_ff @(posedge spi_clk_i) begin
        if (spi_rst_i) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            half_q    <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_q    <= '0;
            fbo_q     <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            cs_q      <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            half_q    <= half_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            fbo_q     <= fbo_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.spi_SCK_o  = sck_q;
    assign bus.spi_MOSI_o = mosi_q;
    assign bus.spi_CS_o   = cs_q;
    assign bus.spi_data_o = data_q;
    assign bus.spi_done_o = done_q;
    assign bus.spi_busy_o = busy_q;
endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master: stimulus queues expected frames, a bus
// monitor measures SCK timing, captures MOSI and checks each completed transfer.
module tb_sd_spi_master;
    typedef struct {
        logic [47:0] data;
        logic [47:0] cap;
        int          lat;
        int          half;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic loopback;
    logic [47:0] card_word;
    logic card_bit;
    int   card_k;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;

    int tog = 0;
    int since = 0;
    int bad_half = 0;
    logic [47:0] cap = '0;
    logic prev_cs = 1'b1;
    logic prev_sck = 1'b0;
    logic prev_done = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    sd_spi_master_if bus();

    sd_spi_master dut (
        .spi_clk_i (clk),
        .spi_rst_i (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Card model: shifts its response out LSB first, advancing on each SCK fall.
    assign card_k = (tog / 2 > 47) ? 47 : tog / 2;
    assign card_bit = card_word[card_k];
    assign bus.spi_MISO_i = loopback ? bus.spi_MOSI_o : card_bit;

    function automatic logic [47:0] bitrev(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = v[47-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            tog = 0;
            since = 0;
            bad_half = 0;
            cap = '0;
        end else begin
            if (prev_cs && !bus.spi_CS_o) begin
                tog = 0;
                since = 0;
                bad_half = 0;
                cap = '0;
            end else begin
                since++;
            end
            if (bus.spi_SCK_o != prev_sck) begin
                if (tog > 0 && sb.size() > 0 && since != sb[0].half) bad_half++;
                if (bus.spi_SCK_o) cap = {cap[46:0], bus.spi_MOSI_o};
                tog++;
                since = 0;
            end
            if (bus.spi_done_o && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 48'd1, 48'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rx_data", bus.spi_data_o, mon_e.data);
                    chk("mosi_bits", cap, mon_e.cap);
                    chk("latency", 48'(cyc - t0), 48'(mon_e.lat));
                    chk("sck_toggles", 48'(tog), 48'd96);
                    chk("sck_half_errors", 48'(bad_half), 48'd0);
                    chk("cs_hold", 48'(since), 48'(mon_e.half));
                    chk("cs_at_done", 48'(bus.spi_CS_o), 48'd1);
                    chk("mosi_at_done", 48'(bus.spi_MOSI_o), 48'd1);
                end
            end
        end
        prev_cs = bus.spi_CS_o;
        prev_sck = bus.spi_SCK_o;
        prev_done = bus.spi_done_o;
    end

    task automatic begin_xfer(input logic [47:0] ins, input logic f, input logic [1:0] d,
                              input logic [47:0] ed, input logic [47:0] ec,
                              input int lat, input int h);
        exp_t e;
        e.data = ed;
        e.cap = ec;
        e.lat = lat;
        e.half = h;
        sb.push_back(e);
        @(negedge clk);
        bus.instruction_sd_i = ins;
        bus.spi_fbo_i = f;
        bus.clock_divider_i = d;
        bus.spi_start_i = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.spi_done_o && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.spi_done_o) chk("done_timeout", 48'd0, 48'd1);
    endtask

    task automatic finish_xfer();
        wait_done();
        bus.spi_start_i = 1'b0;
        @(negedge clk);
        chk("done_release", 48'(bus.spi_done_o), 48'd0);
        chk("busy_release", 48'(bus.spi_busy_o), 48'd0);
    endtask

    initial begin
        int n;
        logic ok;
        rst = 1'b1;
        loopback = 1'b1;
        card_word = '0;
        bus.spi_start_i = 1'b0;
        bus.instruction_sd_i = '0;
        bus.spi_fbo_i = 1'b1;
        bus.clock_divider_i = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 48'(bus.spi_SCK_o), 48'd0);
        chk("rst_mosi", 48'(bus.spi_MOSI_o), 48'd1);
        chk("rst_cs", 48'(bus.spi_CS_o), 48'd1);
        chk("rst_done", 48'(bus.spi_done_o), 48'd0);
        chk("rst_busy", 48'(bus.spi_busy_o), 48'd0);
        chk("rst_data", bus.spi_data_o, 48'd0);
        rst = 1'b0;
        @(negedge clk);

        // CMD0, MSB first, fastest rate, MISO looped back to MOSI
        begin_xfer(48'h400000000095, 1'b1, 2'd0, 48'h400000000095, 48'h400000000095, 197, 2);
        finish_xfer();

        // LSB first, H=4, card returns a fixed response
        loopback = 1'b0;
        card_word = 48'hFFFFFF01AA55;
        begin_xfer(48'h48000001AA87, 1'b0, 2'd1, 48'hFFFFFF01AA55,
                   bitrev(48'h48000001AA87), 393, 4);
        finish_xfer();
        loopback = 1'b1;

        // Slow init rate, H=128
        begin_xfer(48'h7700000000FF, 1'b1, 2'd3, 48'h7700000000FF, 48'h7700000000FF, 12545, 128);
        finish_xfer();

        // Inputs changed mid-transfer must not affect bits or timing
        begin_xfer(48'hA5C30F1E7788, 1'b1, 2'd0, 48'hA5C30F1E7788, 48'hA5C30F1E7788, 197, 2);
        repeat (20) @(negedge clk);
        bus.instruction_sd_i = 48'h0;
        bus.clock_divider_i = 2'd3;
        bus.spi_fbo_i = 1'b0;
        finish_xfer();

        // Extra start pulse mid-transfer is ignored; done held while start stays high
        begin_xfer(48'h123456789ABC, 1'b1, 2'd0, 48'h123456789ABC, 48'h123456789ABC, 197, 2);
        repeat (30) @(negedge clk);
        bus.spi_start_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.spi_start_i = 1'b1;
        wait_done();
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!bus.spi_done_o || bus.spi_busy_o || !bus.spi_CS_o) ok = 1'b0;
        end
        chk("done_held", 48'(ok), 48'd1);
        bus.spi_start_i = 1'b0;
        @(negedge clk);
        chk("done_drop", 48'(bus.spi_done_o), 48'd0);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.spi_CS_o || bus.spi_busy_o) ok = 1'b0;
        end
        chk("idle_after_handshake", 48'(ok), 48'd1);

        // Start dropped mid-transfer: transfer completes, done lasts one cycle
        begin_xfer(48'h0F0F0F0F0F0F, 1'b1, 2'd0, 48'h0F0F0F0F0F0F, 48'h0F0F0F0F0F0F, 197, 2);
        repeat (40) @(negedge clk);
        bus.spi_start_i = 1'b0;
        wait_done();
        @(negedge clk);
        chk("done_one_cycle", 48'(bus.spi_done_o), 48'd0);

        // Reset during SCK period 20, start still high
        repeat (2) @(negedge clk);
        bus.instruction_sd_i = 48'hDEADBEEFCAFE;
        bus.spi_fbo_i = 1'b1;
        bus.clock_divider_i = 2'd0;
        bus.spi_start_i = 1'b1;
        repeat (2) @(negedge clk);
        n = 0;
        while (tog < 40 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_period_20", 48'(tog >= 40), 48'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs", 48'(bus.spi_CS_o), 48'd1);
        chk("midrst_sck", 48'(bus.spi_SCK_o), 48'd0);
        chk("midrst_mosi", 48'(bus.spi_MOSI_o), 48'd1);
        chk("midrst_busy", 48'(bus.spi_busy_o), 48'd0);
        chk("midrst_done", 48'(bus.spi_done_o), 48'd0);
        chk("midrst_data", bus.spi_data_o, 48'd0);
        @(negedge clk);

        // Start held through reset release begins a fresh transfer immediately
        begin
            exp_t e;
            e.data = 48'hDEADBEEFCAFE;
            e.cap = 48'hDEADBEEFCAFE;
            e.lat = 197;
            e.half = 2;
            sb.push_back(e);
        end
        rst = 1'b0;
        t0 = cyc;
        finish_xfer();

        chk("scoreboard_empty", 48'(sb.size()), 48'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_spi_master.md
SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 SHALL have ports: spi_clk_i  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have: spi_rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: spi_start_i  input  1  transfer request, level, held until spi_done_o seen.
REQ-004 SHALL have: instruction_sd_i  input  48  command frame to transmit.
REQ-005 SHALL have: spi_fbo_i  input  1  bit order: 1 = MSB first, 0 = LSB first.
REQ-006 SHALL have: clock_divider_i  input  2  SCK rate select.
REQ-007 SHALL have: spi_MISO_i  input  1  serial data from SD card.
REQ-008 SHALL have: spi_SCK_o  output  1  serial clock; idle low (mode 0).
REQ-009 SHALL have: spi_MOSI_o  output  1  serial data to card; idle high.
REQ-010 SHALL have: spi_CS_o  output  1  chip select, active-low.
REQ-011 SHALL have: spi_data_o  output  48  frame received during last transfer.
REQ-012 SHALL have: spi_done_o  output  1  transfer-complete flag.
REQ-013 SHALL have: spi_busy_o  output  1  high in any state other than IDLE and DONE.

Function
REQ-014 SHALL derive SCK half-period H from clock_divider_i: 0->2, 1->4, 2->8, 3->128 spi_clk_i cycles.
REQ-015 SHALL use states IDLE, CS_SETUP, SHIFT, CS_HOLD and DONE.
REQ-016 IDLE: on spi_start_i=1, SHALL latch instruction_sd_i, spi_fbo_i and clock_divider_i, and enter CS_SETUP on the next edge.
REQ-017 CS_SETUP: SHALL drive spi_CS_o=0 and spi_MOSI_o=first bit, hold for H cycles, then enter SHIFT.
REQ-018 SHIFT: SHALL toggle SCK every H cycles, rising edge first; exactly 48 SCK periods (96 toggles).
REQ-019 SHALL sample spi_MISO_i on the cycle SCK rises.
REQ-020 SHALL present the next MOSI bit on the cycle SCK falls; the first bit is already valid before the first rise.
REQ-021 Bit order: fbo=1 SHALL send bit 47 first and place the first received bit in bit 47. fbo=0 SHALL send bit 0 first and place the first received bit in bit 0.
REQ-022 After the 48th falling edge SHALL enter CS_HOLD: SCK low, CS still low, for H cycles.
REQ-023 Leaving CS_HOLD SHALL enter DONE, with the full received frame on spi_data_o, spi_CS_o=1, spi_MOSI_o=1, and spi_done_o=1.
REQ-024 DONE: spi_done_o SHALL stay 1 until spi_start_i=0, then return to IDLE next cycle with spi_done_o=0 (four-phase handshake).
REQ-025 Total latency, start-sampled to spi_done_o=1, SHALL be 1 + H + 96H + H cycles (e.g. 197 at H=2).
REQ-026 Changes on instruction_sd_i, spi_fbo_i or clock_divider_i during a transfer SHALL have no effect.
REQ-027 spi_start_i rising while busy SHALL be ignored.
REQ-028 spi_start_i dropping mid-transfer SHALL NOT abort the transfer; the block then reaches DONE, sees start low and returns to IDLE.
REQ-029 spi_data_o SHALL change only on entry to DONE and hold its value until the next DONE.
REQ-030 Bit counter SHALL be 6 bits, count 0..47 with no wrap, and the SCK divider counter SHALL be 7 bits.

Reset
REQ-031 With spi_rst_i=1 at an edge, SHALL go to IDLE regardless of state, including mid-SHIFT.
REQ-032 Reset values: spi_SCK_o=0, spi_MOSI_o=1, spi_CS_o=1, spi_done_o=0, spi_busy_o=0, spi_data_o=0, all counters 0.
REQ-033 A partial frame SHALL NOT reach spi_data_o after reset.
REQ-034 spi_start_i held high through reset release SHALL start a new transfer on the first post-reset edge.

Verification
REQ-035 CMD0 MSB-first: instruction 48'h400000000095, fbo=1, div=0, MISO tied to MOSI -> MOSI sequence 0,1,0..., spi_data_o=48'h400000000095, done at cycle 197 after start.
REQ-036 LSB-first with card model returning 48'hFFFFFF01AA55: fbo=0, div=1 -> spi_data_o=48'hFFFFFF01AA55, 48 SCK periods of 8 cycles each.
REQ-037 Slow init rate: div=3 -> SCK high/low 128 cycles each, CS low 128 cycles before the first rise and 128 after the last fall.
REQ-038 Reset at SCK period 20 mid-SHIFT -> next cycle CS=1, SCK=0, MOSI=1, busy=0; spi_data_o keeps its previous value or 0 after reset.
REQ-039 Handshake: hold start 50 cycles past done -> done stays 1; drop start -> done=0 and IDLE in 1 cycle; a second start pulse during a transfer is ignored.
REQ-040 Input change: alter instruction_sd_i and clock_divider_i mid-transfer -> transmitted bits and SCK period are unchanged.
